// File: rtl/rei_pkg.sv
// Shared types and constants for the rei core's machine-mode trap path.
package rei_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned CAUSE_W        = 6;
  localparam int unsigned MCAUSE_IRQ_BIT = XLEN - 1;

  localparam logic [XLEN-1:0] MIP_M_MASK          = 64'h0000_0000_0000_0aaa;
  localparam logic [1:0]      MTVEC_MODE_VECTORED = 2'b01;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  localparam logic [XLEN-1:0] MSTATUS_WRITE_MASK = 64'h0000_0000_0000_1888;
  localparam logic [XLEN-1:0] MSTATUS_READ_MASK  = 64'h0000_000f_0000_1888;
  // SXL/UXL field positions and their fixed XLEN_64 encoding
  localparam logic [XLEN-1:0] MSTATUS_XL_FIELD   = 64'h0000_000f_0000_0000;
  localparam logic [XLEN-1:0] MSTATUS_XL_64      = 64'h0000_000a_0000_0000;
  localparam logic [XLEN-1:0] RESET_MSTATUS      = 64'h0000_000a_0000_0000;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [1:0] {
    PrivU = 2'b00,
    PrivS = 2'b01,
    PrivM = 2'b11
  } priv_lvl_e;

  typedef enum logic [1:0] {
    TrapIdle     = 2'b00,
    TrapDrain    = 2'b01,
    TrapRedirect = 2'b10
  } trap_state_e;

  typedef struct packed {
    logic               valid;
    logic [CAUSE_W-1:0] cause;
    logic [XLEN-1:0]    tval;
  } exc_s;

  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

  // Only U and M are implemented, so S-level (01) and reserved (10) MPP writes are dropped.
  function automatic logic mpp_legal(input logic [1:0] mpp);
    return (mpp == PrivU) || (mpp == PrivM);
  endfunction

endpackage

// File: rtl/rei_irq_prio.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > SEI > SSI > STI.
module rei_irq_prio
  import rei_pkg::*;
(
  input  logic [XLEN-1:0] irq_pend_i,
  output logic            irq_valid_o,
  output logic [3:0]      irq_code_o
);

  always_comb begin
    irq_valid_o = |(irq_pend_i & MIP_M_MASK);
    irq_code_o  = 4'd0;
    if (irq_pend_i[11]) begin
      irq_code_o = 4'd11;
    end else if (irq_pend_i[3]) begin
      irq_code_o = 4'd3;
    end else if (irq_pend_i[7]) begin
      irq_code_o = 4'd7;
    end else if (irq_pend_i[9]) begin
      irq_code_o = 4'd9;
    end else if (irq_pend_i[1]) begin
      irq_code_o = 4'd1;
    end else if (irq_pend_i[5]) begin
      irq_code_o = 4'd5;
    end
  end

endmodule

// File: rtl/rei_trap_ctrl.sv
// Machine-mode trap controller: owns mstatus/mepc/mcause/mtval and sequences kill/drain/redirect.
// Define REI_TRAP_VECTORED_EN to honour vectored mtvec mode for interrupts.
module rei_trap_ctrl
  import rei_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            commit_valid_i,
  input  logic [XLEN-1:0] commit_pc_i,
  input  exc_s            commit_exc_i,
  input  logic            commit_mret_i,
  output logic            commit_kill_o,
  input  logic [XLEN-1:0] mip_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_waddr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output priv_lvl_e       priv_lvl_o,
  output logic            flush_o,
  input  logic            drain_done_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  priv_lvl_e       priv_q, priv_d;

  logic [XLEN-1:0] irq_pend;
  logic            irq_valid;
  logic [3:0]      irq_code;
  logic            in_idle, irq_en;
  logic            take_irq, take_exc, take_mret, take_trap;
  logic [XLEN-1:0] trap_target;

  assign irq_pend = mip_i & mie_i;

  rei_irq_prio u_irq_prio (
    .irq_pend_i  (irq_pend),
    .irq_valid_o (irq_valid),
    .irq_code_o  (irq_code)
  );

  assign in_idle   = (state_q == TrapIdle);
  assign irq_en    = mstatus_q[MSTATUS_MIE] || (priv_q == PrivU);
  assign take_irq  = in_idle && commit_valid_i && irq_en && irq_valid;
  assign take_exc  = in_idle && commit_valid_i && !take_irq && commit_exc_i.valid;
  assign take_mret = in_idle && commit_valid_i && !take_irq && !commit_exc_i.valid &&
                     commit_mret_i;
  assign take_trap = take_irq || take_exc;

  assign commit_kill_o = take_trap || take_mret;

  always_comb begin
    trap_target = align4(mtvec_i);
`ifdef REI_TRAP_VECTORED_EN
    if (take_irq && (mtvec_i[1:0] == MTVEC_MODE_VECTORED)) begin
      trap_target = align4(mtvec_i) + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    mstatus_d     = mstatus_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    priv_d        = priv_q;
    redirect_pc_d = redirect_pc_q;

    unique case (state_q)
      TrapIdle:     if (commit_kill_o) state_d = TrapDrain;
      TrapDrain:    if (drain_done_i) state_d = TrapRedirect;
      TrapRedirect: if (redirect_ready_i) state_d = TrapIdle;
      default:      state_d = TrapIdle;
    endcase

    if (take_trap) begin
      mepc_d   = align4(commit_pc_i);
      mcause_d = take_irq ? {1'b1, {(XLEN-5){1'b0}}, irq_code}
                          : {{(XLEN-CAUSE_W){1'b0}}, commit_exc_i.cause};
      mtval_d  = take_irq ? '0 : commit_exc_i.tval;
      mstatus_d[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]                   = 1'b0;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
      priv_d        = PrivM;
      redirect_pc_d = trap_target;
    end else if (take_mret) begin
      mstatus_d[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE]                  = 1'b1;
      mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PrivU;
      priv_d        = priv_lvl_e'(mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
      redirect_pc_d = mepc_q;
    end else if (csr_we_i) begin
      case (csr_waddr_i)
        CSR_MSTATUS: begin
          mstatus_d = (mstatus_q & ~MSTATUS_WRITE_MASK) | (csr_wdata_i & MSTATUS_WRITE_MASK);
          if (!mpp_legal(csr_wdata_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO])) begin
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          end
        end
        CSR_MEPC:   mepc_d   = align4(csr_wdata_i);
        CSR_MCAUSE: mcause_d = csr_wdata_i;
        CSR_MTVAL:  mtval_d  = csr_wdata_i;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= TrapIdle;
      mstatus_q     <= RESET_MSTATUS;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      priv_q        <= PrivM;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mstatus_q     <= mstatus_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      priv_q        <= priv_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign mstatus_o        = (mstatus_q & MSTATUS_READ_MASK & ~MSTATUS_XL_FIELD) | MSTATUS_XL_64;
  assign mepc_o           = mepc_q;
  assign mcause_o         = mcause_q;
  assign mtval_o          = mtval_q;
  assign priv_lvl_o       = priv_q;
  assign flush_o          = (state_q == TrapDrain);
  assign redirect_valid_o = (state_q == TrapRedirect);
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: doc/rei_trap_ctrl.md
# rei_trap_ctrl

Machine-mode trap controller for the RV64 core. It owns mstatus, mepc, mcause and mtval, and arbitrates between interrupts, synchronous exceptions and mret at the commit boundary. On a trap it kills the committing instruction, updates the trap CSRs, drains the pipeline, then issues a PC redirect to the fetch stage. It sits between the commit stage, the CSR file (which owns mtvec/mie/mip) and instruction fetch.

## Interface
- XLEN, rei_pkg::XLEN (64): data width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- commit_valid_i  in  1  instruction at commit this cycle
- commit_pc_i  in  XLEN  its PC
- commit_exc_i  in  exc_s  synchronous exception (valid/cause/tval)
- commit_mret_i  in  1  instruction is mret
- commit_kill_o  out  1  squash committing instruction (combinational)
- mip_i / mie_i  in  XLEN  pending / enabled interrupts
- mtvec_i  in  XLEN  trap vector CSR
- csr_we_i, csr_waddr_i[11:0], csr_wdata_i[XLEN]  in  CSR-instruction write port
- mstatus_o, mepc_o, mcause_o, mtval_o  out  XLEN  CSR read values
- priv_lvl_o  out  priv_lvl_e  current privilege
- flush_o  out  1  pipeline flush request
- drain_done_i  in  1  pipeline empty
- redirect_valid_o  out  1  redirect request
- redirect_pc_o  out  XLEN  target PC
- redirect_ready_i  in  1  fetch accepts redirect

## Operation
- FSM: IDLE -> DRAIN -> REDIRECT -> IDLE.
- Event selection, evaluated only in IDLE with commit_valid_i=1:
  - Interrupt: mstatus.MIE=1 or priv=U, and |(mip_i & mie_i & 0xAAA). Highest priority.
  - Otherwise commit_exc_i.valid.
  - Otherwise commit_mret_i.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5).
- Any event asserts commit_kill_o and moves IDLE -> DRAIN.
- Trap update (interrupt or exception):
  - mepc = {pc[XLEN-1:2],2'b00}.
  - mcause = {irq, code}. Interrupts set bit XLEN-1.
  - mtval = exc.tval, or 0 for interrupts.
  - MPIE=MIE, MIE=0, MPP=priv, priv=M.
  - Target = {mtvec[XLEN-1:2],2'b00}.
- mret update: MIE=MPIE, MPIE=1, priv=MPP, MPP=U. Target = mepc.
- CSR writes, honoured only when no event fires the same cycle (trap wins):
  - 0x300 mstatus: only MSTATUS_WRITE_MASK bits change. MPP write values 01/10 are illegal and leave MPP unchanged.
  - 0x341 mepc: bits [1:0] forced to 0.
  - 0x342 mcause, 0x343 mtval: full width.
- mstatus_o = mstatus & MSTATUS_READ_MASK. SXL/UXL always read XLEN_64.
- DRAIN: flush_o=1 until drain_done_i. commit inputs are ignored.
- REDIRECT: redirect_valid_o=1, redirect_pc_o held stable until redirect_ready_i.

## Timing
- Event accepted in cycle T:
  - commit_kill_o asserted in T.
  - CSRs and priv updated at edge T+1.
  - flush_o asserted from T+1.
- drain_done_i seen high in cycle D: REDIRECT from D+1. drain_done_i already high at T+1 gives redirect_valid_o at T+2.
- Handshake completes in the cycle where redirect_valid_o && redirect_ready_i. IDLE next cycle, so a new event can be accepted one cycle after the handshake.
- Reset values:
  - state IDLE; flush_o, redirect_valid_o, commit_kill_o = 0; redirect_pc_o = 0.
  - mstatus = RESET_MSTATUS; mepc, mcause, mtval = 0; priv = M.
- Reset mid-operation (DRAIN/REDIRECT) returns to IDLE with no redirect issued.

## Configuration
- REI_TRAP_VECTORED_EN defined: if mtvec[1:0]=01, the interrupt target is base + 4*code. Exceptions always go to base.
- Undefined: mtvec[1:0] is ignored and every trap goes to base.

## Structure
- rei_pkg additions:
  - trap_state_e (IDLE/DRAIN/REDIRECT).
  - MCAUSE_IRQ_BIT = XLEN-1.
  - MIP_M_MASK.
  - MTVEC_MODE_VECTORED = 2'b01.
- Sub-module rei_irq_prio: combinational fixed-priority encoder. Input: pending & enabled mask. Outputs: valid, 4-bit code.

## Test plan
- ecall (cause 11) at 0x80000010, mtvec 0x80001000, MIE=1 -> mcause 11, mepc 0x80000010, MIE=0/MPIE=1/MPP=11, drain_done at T+3, redirect 0x80001000.
- MTIP pending with MTIE set and MIE=1, commit 0x80000100, mtvec 0x80001001 -> kill, mcause 0x8000000000000007. Redirect 0x8000101C with the macro, 0x80001000 without.
- MEIP and MTIP pending simultaneously with illegal-instruction exc -> mcause 0x800000000000000B, mtval 0.
- mret with MPIE=1, MPP=00, mepc 0x80000200 -> priv U, MIE=1, MPP=00, redirect 0x80000200.
- csr write 0x300 of all ones -> read 0x0000000A00001888. Subsequent write MPP=01 leaves MPP=11.
- Reset in DRAIN, and redirect_ready_i held low 5 cycles (redirect_pc_o stable) -> all outputs at reset values, FSM in IDLE.
